// File: rtl/ring_counter_multi_mode.sv
// One-hot ring sequencer: rotates left/right by a programmable step, holds or loads.
// Define RING_ONEHOT_CHECK_EN to build the one-hot integrity checker with auto-recovery.
module ring_counter_multi_mode #(
    parameter int WIDTH     = 280,
    parameter int RESET_POS = WIDTH - 1,
    parameter int STEP_W    = $clog2(WIDTH)
) (
    input  logic              clock0,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  load_data,
    output logic [WIDTH-1:0]  out,
    output logic [STEP_W-1:0] pos,
    output logic              wrap,
    output logic              onehot_err
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    // One extra bit so WIDTH itself and out-of-range steps are representable.
    localparam int                SWX       = STEP_W + 1;
    localparam logic [SWX-1:0]    WIDTH_X   = SWX'(WIDTH);
    localparam logic [WIDTH-1:0]  ONES      = '1;
    localparam logic [WIDTH-1:0]  RESET_VEC = {{(WIDTH-1){1'b0}}, 1'b1} << RESET_POS;
    localparam logic [STEP_W-1:0] RESET_IDX = STEP_W'(RESET_POS);

    logic [WIDTH-1:0]  out_q, out_d;
    logic [STEP_W-1:0] pos_q, pos_d;
    logic              wrap_q, wrap_d;
    logic              step_ok;

    function automatic logic [STEP_W-1:0] lowest_set(input logic [WIDTH-1:0] vec);
        logic [STEP_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = STEP_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [STEP_W-1:0] pos_left(input logic [STEP_W-1:0] p,
                                                   input logic [STEP_W-1:0] s);
        logic [SWX-1:0] sum;
        sum = {1'b0, p} + {1'b0, s};
        if (sum >= WIDTH_X) sum = sum - WIDTH_X;
        return STEP_W'(sum);
    endfunction

    // Borrow is folded in by adding WIDTH first, so no negative value ever forms.
    function automatic logic [STEP_W-1:0] pos_right(input logic [STEP_W-1:0] p,
                                                    input logic [STEP_W-1:0] s);
        logic [SWX-1:0] diff;
        if (p >= s) diff = {1'b0, p} - {1'b0, s};
        else        diff = {1'b0, p} + WIDTH_X - {1'b0, s};
        return STEP_W'(diff);
    endfunction

`ifdef RING_ONEHOT_CHECK_EN
    logic err_q, err_d;

    function automatic logic is_onehot(input logic [WIDTH-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction
`endif

    assign step_ok = (step != '0) && ({1'b0, step} < WIDTH_X);

    always_comb begin
        out_d  = out_q;
        pos_d  = pos_q;
        wrap_d = 1'b0;
`ifdef RING_ONEHOT_CHECK_EN
        err_d  = 1'b0;
        if (!is_onehot(out_q)) begin
            out_d = RESET_VEC;
            pos_d = RESET_IDX;
            err_d = 1'b1;
        end else
`endif
        if (en) begin
            case (mode_e'(mode))
                MODE_LEFT: begin
                    if (step_ok) begin
                        out_d  = (out_q << step) | (out_q >> (WIDTH_X - {1'b0, step}));
                        pos_d  = pos_left(pos_q, step);
                        wrap_d = |(out_q & ~(ONES >> step));
                    end
                end
                MODE_RIGHT: begin
                    if (step_ok) begin
                        out_d  = (out_q >> step) | (out_q << (WIDTH_X - {1'b0, step}));
                        pos_d  = pos_right(pos_q, step);
                        wrap_d = |(out_q & ~(ONES << step));
                    end
                end
                MODE_LOAD: begin
                    out_d = load_data;
                    pos_d = lowest_set(load_data);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            out_q  <= RESET_VEC;
            pos_q  <= RESET_IDX;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef RING_ONEHOT_CHECK_EN
    always_ff @(posedge clock0) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign onehot_err = err_q;
`else
    assign onehot_err = 1'b0;
`endif

    assign out  = out_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_multi_mode.sv
// Directed table-driven bench for ring_counter_multi_mode at WIDTH=8, RESET_POS=7.
module tb_ring_counter_multi_mode;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clock0 = 1'b0;
    logic          reset;
    logic          en;
    logic [1:0]    mode;
    logic [SW-1:0] step;
    logic [W-1:0]  load_data;
    logic [W-1:0]  out;
    logic [SW-1:0] pos;
    logic          wrap;
    logic          onehot_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         name;
        logic          rst;
        logic          en;
        logic [1:0]    mode;
        logic [SW-1:0] step;
        logic [W-1:0]  ld;
        logic [W-1:0]  x_out;
        logic [SW-1:0] x_pos;
        logic          x_wrap;
        logic          x_err;
    } vec_t;

    vec_t vecs[$];

    ring_counter_multi_mode #(.WIDTH(W), .RESET_POS(7), .STEP_W(SW)) dut (
        .clock0    (clock0),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .step      (step),
        .load_data (load_data),
        .out       (out),
        .pos       (pos),
        .wrap      (wrap),
        .onehot_err(onehot_err)
    );

    always #5 clock0 = ~clock0;

    task automatic add(input string nm, input logic r, input logic e, input logic [1:0] m,
                       input logic [SW-1:0] s, input logic [W-1:0] ld, input logic [W-1:0] xo,
                       input logic [SW-1:0] xp, input logic xw, input logic xe);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e; v.mode = m; v.step = s; v.ld = ld;
        v.x_out = xo; v.x_pos = xp; v.x_wrap = xw; v.x_err = xe;
        vecs.push_back(v);
    endtask

    task automatic apply_check(input vec_t v);
        reset = v.rst; en = v.en; mode = v.mode; step = v.step; load_data = v.ld;
        @(posedge clock0);
        #1;
        checks++;
        if (out !== v.x_out) begin
            errors++;
            $display("FAIL %s out: got %h want %h", v.name, out, v.x_out);
        end
        checks++;
        if (pos !== v.x_pos) begin
            errors++;
            $display("FAIL %s pos: got %0d want %0d", v.name, pos, v.x_pos);
        end
        checks++;
        if (wrap !== v.x_wrap) begin
            errors++;
            $display("FAIL %s wrap: got %b want %b", v.name, wrap, v.x_wrap);
        end
        checks++;
        if (onehot_err !== v.x_err) begin
            errors++;
            $display("FAIL %s onehot_err: got %b want %b", v.name, onehot_err, v.x_err);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'b00; step = '0; load_data = '0;

        //  name          rst en mode   step  load   out    pos wrap err
        add("reset",        1, 0, 2'b00, 3'd0, 8'h00, 8'h80, 3'd7, 0, 0);
        add("l1_wrap",      0, 1, 2'b01, 3'd1, 8'h00, 8'h01, 3'd0, 1, 0);
        add("l2",           0, 1, 2'b01, 3'd2, 8'h00, 8'h04, 3'd2, 0, 0);
        add("r2",           0, 1, 2'b10, 3'd2, 8'h00, 8'h01, 3'd0, 0, 0);
        add("r3_wrap",      0, 1, 2'b10, 3'd3, 8'h00, 8'h20, 3'd5, 1, 0);
        for (int i = 0; i < 4; i++)
            add("en0_hold", 0, 0, 2'b10, 3'd3, 8'h00, 8'h20, 3'd5, 0, 0);
        add("step0_hold",   0, 1, 2'b01, 3'd0, 8'h00, 8'h20, 3'd5, 0, 0);
        add("mode0_hold",   0, 1, 2'b00, 3'd3, 8'h00, 8'h20, 3'd5, 0, 0);
        add("load10",       0, 1, 2'b11, 3'd0, 8'h10, 8'h10, 3'd4, 0, 0);
        add("l7_wrap",      0, 1, 2'b01, 3'd7, 8'h00, 8'h08, 3'd3, 1, 0);
        add("r1",           0, 1, 2'b10, 3'd1, 8'h00, 8'h04, 3'd2, 0, 0);
        add("r2b",          0, 1, 2'b10, 3'd2, 8'h00, 8'h01, 3'd0, 0, 0);
        add("r1_wrap",      0, 1, 2'b10, 3'd1, 8'h00, 8'h80, 3'd7, 1, 0);
        add("l7_from80",    0, 1, 2'b01, 3'd7, 8'h00, 8'h40, 3'd6, 1, 0);
        add("en0_noload",   0, 0, 2'b11, 3'd0, 8'h55, 8'h40, 3'd6, 0, 0);
        add("load_rst",     1, 1, 2'b11, 3'd0, 8'h55, 8'h80, 3'd7, 0, 0);

        foreach (vecs[i]) apply_check(vecs[i]);
        vecs.delete();

        // Multi-bit loads: either recovered by the checker or left rotating.
        add("load18",       0, 1, 2'b11, 3'd0, 8'h18, 8'h18, 3'd3, 0, 0);
`ifdef RING_ONEHOT_CHECK_EN
        add("recover18",    0, 1, 2'b01, 3'd1, 8'h00, 8'h80, 3'd7, 0, 1);
        add("err_clear",    0, 1, 2'b00, 3'd0, 8'h00, 8'h80, 3'd7, 0, 0);
        add("load00",       0, 1, 2'b11, 3'd0, 8'h00, 8'h00, 3'd0, 0, 0);
        add("recover00",    0, 0, 2'b01, 3'd1, 8'h00, 8'h80, 3'd7, 0, 1);
`else
        add("rot18",        0, 1, 2'b01, 3'd1, 8'h00, 8'h30, 3'd4, 0, 0);
        add("hold30",       0, 1, 2'b00, 3'd0, 8'h00, 8'h30, 3'd4, 0, 0);
        add("r5_wrap30",    0, 1, 2'b10, 3'd5, 8'h00, 8'h81, 3'd7, 1, 0);
        add("load00",       0, 1, 2'b11, 3'd0, 8'h00, 8'h00, 3'd0, 0, 0);
        add("rot00",        0, 1, 2'b01, 3'd1, 8'h00, 8'h00, 3'd1, 0, 0);
`endif
        add("final_rst",    1, 0, 2'b00, 3'd0, 8'h00, 8'h80, 3'd7, 0, 0);

        foreach (vecs[i]) apply_check(vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
